xor_descrambler: RTL and testbench
==================================

# xor_descrambler

Receive-side counterpart of the 4-bit XOR data scrambler. Accepts framed 4-bit scrambled nibbles on a valid/ready stream, regenerates the same additive keystream from a 7-bit LFSR reseeded at every start-of-frame, and XORs it back out to recover the plaintext. It sits between the link receiver and the nibble consumer, with one registered output stage.

## Interface
- SEED, 7'h7F, LFSR value loaded at reset and on every accepted start-of-frame beat; must be nonzero, and a value of 0 turns the block into a pass-through.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  4  scrambled nibble.
- in_valid  in  1  in_data, in_sof and in_eof are valid.
- in_sof  in  1  first beat of a frame.
- in_eof  in  1  last beat of a frame.
- in_ready  out  1  block can accept a beat this cycle.
- out_data  out  4  descrambled nibble.
- out_valid  out  1  output beat is valid.
- out_sof  out  1  registered copy of in_sof for the beat.
- out_eof  out  1  registered copy of in_eof for the beat.
- out_ready  in  1  consumer accepts the output beat.
- beat_cnt  out  8  beats accepted in the current frame, counting the sof beat; saturates at 255.
- err_nosof  out  1  one-cycle pulse when a beat is dropped outside a frame.

## Operation
- Accept is defined as in_valid && in_ready at a rising edge. in_ready = !out_valid || out_ready (combinational).
- LFSR state s[6:0]:
  - Each step produces key bit k = s[6] ^ s[5]; the next state is {s[5:0], k}.
  - One beat takes 4 steps. The first k generated is key[3], the last is key[0].
  - out_data = in_data ^ key.
- Keystream base for each beat:
  - An in_sof beat uses a keystream generated from SEED, regardless of the current state.
  - Any other beat continues from the current s.
  - After the beat, s holds the state reached after the 4th step.
- FSM states are IDLE and ACTIVE. Reset enters IDLE.
  - IDLE, accepted beat with in_sof=1: emit the beat. Go to ACTIVE, or stay in IDLE if in_eof=1 on the same beat (single-beat frame).
  - IDLE, accepted beat with in_sof=0: discard it (no output), leave s unchanged, pulse err_nosof on the next cycle. In IDLE, in_ready obeys the same rule as in ACTIVE.
  - ACTIVE, accepted beat with in_sof=0: emit the beat. in_eof=1 returns to IDLE.
  - ACTIVE, accepted beat with in_sof=1: restart. Reseed, set beat_cnt=1, emit the beat with out_sof=1 and no error. Stay in ACTIVE unless in_eof=1.
- beat_cnt:
  - An accepted sof beat sets it to 1.
  - Other emitted beats increment it, holding at 255.
  - Discarded beats leave it unchanged.
  - It holds its value after eof until the next sof.
- Reset mid-frame: all state is cleared immediately and any pending output beat is lost. The next frame must begin with sof.

## Timing
- Latency: an accepted beat appears on out_* on the next cycle. Throughput is one beat per cycle while out_ready=1.
- Output hold: while out_valid && !out_ready, out_data, out_sof and out_eof stay stable and in_ready=0.
- When an accept coincides with output consumption, the new beat replaces the old one without a bubble.
- out_valid falls after consumption when no new beat was accepted.
- Reset values: out_valid=0, out_data=4'h0, out_sof=0, out_eof=0, beat_cnt=0, err_nosof=0, s=SEED, state=IDLE. in_ready=1 after reset.

## Test plan
- Basic keystream check:
  - Stimulus: SEED=7'h7F, out_ready=1; one 4-beat frame of in_data 4'hF (sof on beat 1, eof on beat 4).
  - Response: out_data F, D, F, 3 on consecutive cycles, each one cycle after its input; out_sof on the first, out_eof on the last; beat_cnt ends at 4.
- Round trip:
  - Stimulus: feed in_data 0,2,0,C as a frame.
  - Response: out_data 0,0,0,0. Feeding the same nibbles again as a new frame yields 0,0,0,0 again, proving the reseed.
- Backpressure:
  - Stimulus: hold out_ready=0 for 3 cycles mid-frame.
  - Response: in_ready=0 and out_* frozen. After release, the sequence continues without loss or duplication and matches the first scenario's values.
- Beat outside a frame:
  - Stimulus: a beat with in_sof=0 in IDLE.
  - Response: no out_valid, err_nosof high for exactly one cycle, beat_cnt and keystream unaffected. A following 4'hF frame gives F, D, F, 3.
- Restart and single-beat frame:
  - Restart stimulus: sof arrives on beat 3 of an open frame.
  - Restart response: that beat decodes as F from 4'hF and beat_cnt=1.
  - Single-beat stimulus: a beat with sof and eof together.
  - Single-beat response: one output carrying both flags, then state IDLE.
- Reset and saturation:
  - Reset stimulus: assert rst_n=0 asynchronously while out_valid=1.
  - Reset response: out_valid drops immediately with all reset values.
  - Saturation stimulus: a 300-beat frame.
  - Saturation response: beat_cnt holds at 255.

Source files
------------

// File: rtl/xor_descrambler_if.sv
// Stream bundle for the nibble descrambler: scrambled input side, recovered
// output side and the per-frame status signals.
interface xor_descrambler_if;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_sof;
    logic       in_eof;
    logic       in_ready;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_sof;
    logic       out_eof;
    logic       out_ready;
    logic [7:0] beat_cnt;
    logic       err_nosof;

    // Driver / consumer side (link receiver plus nibble consumer).
    modport master (
        output in_data, in_valid, in_sof, in_eof, out_ready,
        input  in_ready, out_data, out_valid, out_sof, out_eof, beat_cnt, err_nosof
    );

    // Descrambler side.
    modport slave (
        input  in_data, in_valid, in_sof, in_eof, out_ready,
        output in_ready, out_data, out_valid, out_sof, out_eof, beat_cnt, err_nosof
    );
endinterface

// File: rtl/xor_descrambler.sv
// Additive 4-bit descrambler. A 7-bit LFSR (k = s[6]^s[5], shift left, k in at
// bit 0) is stepped four times per beat; the first key bit is key[3]. The LFSR
// restarts from SEED on every start-of-frame beat. One registered output stage.
module xor_descrambler #(
    parameter logic [6:0] SEED = 7'h7F
) (
    input  logic           clk,
    input  logic           rst_n,
    xor_descrambler_if.slave bus
);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t     state_reg, state_next;
    logic [6:0] s_reg, s_next;
    logic [6:0] base;
    logic [3:0] key;
    logic [6:0] s_after;
    logic       accept;
    logic       emit;
    logic       drop;
    logic       out_valid_reg;
    logic [3:0] out_data_reg;
    logic       out_sof_reg;
    logic       out_eof_reg;
    logic [7:0] beat_cnt_reg;
    logic       err_nosof_reg;

    // Four LFSR steps: returns {key[3:0], state after the 4th step}.
    function automatic logic [10:0] lfsr_beat(input logic [6:0] s0);
        logic [6:0] s;
        logic [3:0] k;
        s = s0;
        k = '0;
        for (int i = 3; i >= 0; i--) begin
            k[i] = s[6] ^ s[5];
            s    = {s[5:0], k[i]};
        end
        return {k, s};
    endfunction

    // The output stage can take a new beat when empty or being drained.
    assign bus.in_ready = !out_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    // Beats are emitted inside a frame or when they open one; others are dropped.
    assign emit         = accept && (bus.in_sof || (state_reg == ACTIVE));
    assign drop         = accept && !bus.in_sof && (state_reg == IDLE);
    assign base         = bus.in_sof ? SEED : s_reg;
    assign {key, s_after} = lfsr_beat(base);
    assign s_next       = emit ? s_after : s_reg;

    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_sof   = out_sof_reg;
    assign bus.out_eof   = out_eof_reg;
    assign bus.beat_cnt  = beat_cnt_reg;
    assign bus.err_nosof = err_nosof_reg;

    // Frame state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: sof opens (or restarts) a frame, eof closes it.
    always_comb begin
        state_next = state_reg;
        if (accept) begin
            if (bus.in_sof) begin
                state_next = bus.in_eof ? IDLE : ACTIVE;
            end else if (state_reg == ACTIVE && bus.in_eof) begin
                state_next = IDLE;
            end
        end
    end

    // Keystream state advances only on emitted beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_reg <= SEED;
        end else begin
            s_reg <= s_next;
        end
    end

    // Output stage: load on emit, hold while stalled, empty once consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= 4'h0;
            out_sof_reg   <= 1'b0;
            out_eof_reg   <= 1'b0;
        end else if (emit) begin
            out_valid_reg <= 1'b1;
            out_data_reg  <= bus.in_data ^ key;
            out_sof_reg   <= bus.in_sof;
            out_eof_reg   <= bus.in_eof;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    // Per-frame beat counter, saturating; holds after eof until the next sof.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_reg <= 8'd0;
        end else if (emit) begin
            if (bus.in_sof) begin
                beat_cnt_reg <= 8'd1;
            end else if (beat_cnt_reg != 8'hFF) begin
                beat_cnt_reg <= beat_cnt_reg + 8'd1;
            end
        end
    end

    // One-cycle error pulse for a beat discarded outside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_nosof_reg <= 1'b0;
        end else begin
            err_nosof_reg <= drop;
        end
    end

endmodule

// File: tb/tb_xor_descrambler.sv
// Directed bench for xor_descrambler: a vector table for streaming frames plus
// hand-written sequences for reset, backpressure, saturation and async reset.
module tb_xor_descrambler;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;

    xor_descrambler_if bus();

    xor_descrambler #(.SEED(7'h7F)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] din;
        logic       sof;
        logic       eof;
        logic       exp_valid;
        logic [3:0] exp_data;
        logic       exp_sof;
        logic       exp_eof;
        logic [7:0] exp_cnt;
        logic       exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input string name, input logic [3:0] din, input logic sof,
                       input logic eof, input logic ev, input logic [3:0] ed,
                       input logic es, input logic ee, input logic [7:0] ec,
                       input logic er);
        vec_t v;
        v.name = name; v.din = din; v.sof = sof; v.eof = eof;
        v.exp_valid = ev; v.exp_data = ed; v.exp_sof = es; v.exp_eof = ee;
        v.exp_cnt = ec; v.exp_err = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        tests_run++;
        if (act != exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] d, input logic s, input logic e);
        bus.in_data  = d;
        bus.in_sof   = s;
        bus.in_eof   = e;
        bus.in_valid = 1'b1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst_n        = 1'b0;
        bus.in_data  = 4'h0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_eof   = 1'b0;
        bus.out_ready = 1'b1;

        // Keystream from 7F: 0,2,0,C  ->  F,D,F,3 for input F.
        add("basic0", 4'hF, 1, 0, 1, 4'hF, 1, 0, 8'd1, 0);
        add("basic1", 4'hF, 0, 0, 1, 4'hD, 0, 0, 8'd2, 0);
        add("basic2", 4'hF, 0, 0, 1, 4'hF, 0, 0, 8'd3, 0);
        add("basic3", 4'hF, 0, 1, 1, 4'h3, 0, 1, 8'd4, 0);
        add("rt0",    4'h0, 1, 0, 1, 4'h0, 1, 0, 8'd1, 0);
        add("rt1",    4'h2, 0, 0, 1, 4'h0, 0, 0, 8'd2, 0);
        add("rt2",    4'h0, 0, 0, 1, 4'h0, 0, 0, 8'd3, 0);
        add("rt3",    4'hC, 0, 1, 1, 4'h0, 0, 1, 8'd4, 0);
        add("rtb0",   4'h0, 1, 0, 1, 4'h0, 1, 0, 8'd1, 0);
        add("rtb1",   4'h2, 0, 0, 1, 4'h0, 0, 0, 8'd2, 0);
        add("rtb2",   4'h0, 0, 0, 1, 4'h0, 0, 0, 8'd3, 0);
        add("rtb3",   4'hC, 0, 1, 1, 4'h0, 0, 1, 8'd4, 0);
        // Restart on beat 3 of an open frame.
        add("rs0",    4'hF, 1, 0, 1, 4'hF, 1, 0, 8'd1, 0);
        add("rs1",    4'hF, 0, 0, 1, 4'hD, 0, 0, 8'd2, 0);
        add("rs2",    4'hF, 1, 0, 1, 4'hF, 1, 0, 8'd1, 0);
        add("rs3",    4'hF, 0, 0, 1, 4'hD, 0, 0, 8'd2, 0);
        add("rs4",    4'hF, 0, 0, 1, 4'hF, 0, 0, 8'd3, 0);
        add("rs5",    4'hF, 0, 1, 1, 4'h3, 0, 1, 8'd4, 0);
        // Single-beat frame, then an out-of-frame beat proves IDLE.
        add("single", 4'hA, 1, 1, 1, 4'hA, 1, 1, 8'd1, 0);
        add("nosof",  4'h5, 0, 0, 0, 4'h0, 0, 0, 8'd1, 1);
        add("after0", 4'hF, 1, 0, 1, 4'hF, 1, 0, 8'd1, 0);
        add("after1", 4'hF, 0, 0, 1, 4'hD, 0, 0, 8'd2, 0);
        add("after2", 4'hF, 0, 0, 1, 4'hF, 0, 0, 8'd3, 0);
        add("after3", 4'hF, 0, 1, 1, 4'h3, 0, 1, 8'd4, 0);

        #12;
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_out_data",  int'(bus.out_data), 0);
        chk("rst_out_sof",   int'(bus.out_sof), 0);
        chk("rst_out_eof",   int'(bus.out_eof), 0);
        chk("rst_beat_cnt",  int'(bus.beat_cnt), 0);
        chk("rst_err",       int'(bus.err_nosof), 0);
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Back-to-back table: each output is checked one cycle after its input.
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].din, vecs[i].sof, vecs[i].eof);
            step();
            chk({vecs[i].name, "_valid"}, int'(bus.out_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                chk({vecs[i].name, "_data"}, int'(bus.out_data), int'(vecs[i].exp_data));
                chk({vecs[i].name, "_sof"},  int'(bus.out_sof),  int'(vecs[i].exp_sof));
                chk({vecs[i].name, "_eof"},  int'(bus.out_eof),  int'(vecs[i].exp_eof));
            end
            chk({vecs[i].name, "_cnt"}, int'(bus.beat_cnt), int'(vecs[i].exp_cnt));
            chk({vecs[i].name, "_err"}, int'(bus.err_nosof), int'(vecs[i].exp_err));
            $display("[TB] vec %s in=%h sof=%b eof=%b -> out=%h v=%b cnt=%0d",
                     vecs[i].name, vecs[i].din, vecs[i].sof, vecs[i].eof,
                     bus.out_data, bus.out_valid, bus.beat_cnt);
        end
        bus.in_valid = 1'b0;
        step();
        chk("drain_valid", int'(bus.out_valid), 0);

        // Backpressure: stall 3 cycles with beat 3 waiting.
        drive(4'hF, 1'b1, 1'b0);
        step();
        chk("bp_b0", int'(bus.out_data), 4'hF);
        drive(4'hF, 1'b0, 1'b0);
        step();
        chk("bp_b1", int'(bus.out_data), 4'hD);
        bus.out_ready = 1'b0;
        drive(4'hF, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk("bp_hold_valid", int'(bus.out_valid), 1);
            chk("bp_hold_data", int'(bus.out_data), 4'hD);
            chk("bp_hold_cnt", int'(bus.beat_cnt), 2);
            $display("[TB] stall cycle %0d out=%h in_ready=%b", c, bus.out_data, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        chk("bp_b2", int'(bus.out_data), 4'hF);
        chk("bp_b2_cnt", int'(bus.beat_cnt), 3);
        drive(4'hF, 1'b0, 1'b1);
        step();
        chk("bp_b3", int'(bus.out_data), 4'h3);
        chk("bp_b3_eof", int'(bus.out_eof), 1);
        chk("bp_b3_cnt", int'(bus.beat_cnt), 4);
        bus.in_valid = 1'b0;
        step();
        chk("bp_drain", int'(bus.out_valid), 0);

        // Saturation: 300-beat frame.
        for (int b = 0; b < 300; b++) begin
            drive(4'h0, (b == 0), (b == 299));
            step();
            if (b == 253) chk("sat_254", int'(bus.beat_cnt), 254);
            if (b == 254) chk("sat_255", int'(bus.beat_cnt), 255);
            if (b == 255) chk("sat_hold", int'(bus.beat_cnt), 255);
        end
        chk("sat_end", int'(bus.beat_cnt), 255);
        chk("sat_eof", int'(bus.out_eof), 1);
        $display("[TB] saturation frame done cnt=%0d", bus.beat_cnt);
        bus.in_valid = 1'b0;
        step();

        // Asynchronous reset while an output beat is pending.
        drive(4'hF, 1'b1, 1'b0);
        step();
        chk("ar_pre_valid", int'(bus.out_valid), 1);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", int'(bus.out_valid), 0);
        chk("ar_data",  int'(bus.out_data), 0);
        chk("ar_sof",   int'(bus.out_sof), 0);
        chk("ar_cnt",   int'(bus.beat_cnt), 0);
        chk("ar_ready", int'(bus.in_ready), 1);
        $display("[TB] async reset applied out_valid=%b cnt=%0d", bus.out_valid, bus.beat_cnt);
        @(negedge clk);
        rst_n = 1'b1;
        // After reset the block is IDLE: a non-sof beat is dropped.
        drive(4'hF, 1'b0, 1'b0);
        step();
        chk("ar_drop_valid", int'(bus.out_valid), 0);
        chk("ar_drop_err", int'(bus.err_nosof), 1);
        bus.in_valid = 1'b0;
        step();
        chk("ar_err_pulse", int'(bus.err_nosof), 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
